// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch sequencer. Owns the fetch PC, drives a
// multi-cycle req/ack instruction-memory port, and presents one F slot to D
// backed by a one-entry skid register. Taken branches/jumps from D are
// applied with MIPS delay-slot semantics.
// Optional build macro: IF_FETCH_EXC_EN (address-error check before issue).
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter logic [31:0] IM_BASE       = 32'h0000_3000,
    parameter int unsigned IM_SIZE_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        F_valid,
    output logic [31:0] F_PC,
    output logic [31:0] F_Instr,
    output logic        F_exc,
    output logic [4:0]  F_excCode
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic        r_tgt_pend;
    logic        r_drop;

    logic        r_valid;
    logic [31:0] r_slot_pc;
    logic [31:0] r_slot_instr;
    logic        r_slot_exc;

    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        r_skid_exc;

    logic        w_consume;
    logic        w_slot_free;
    logic        w_kill;
    logic        w_bad;
    logic        w_ack;
    logic        w_take;
    logic [31:0] w_arr_instr;

`ifdef IF_FETCH_EXC_EN
    // Misaligned or outside [IM_BASE, IM_BASE + 4*IM_SIZE_WORDS).
    function automatic logic f_addr_bad(input logic [31:0] a);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, IM_BASE};
        hi = lo + 33'(4 * IM_SIZE_WORDS);
        return (a[1:0] != 2'b00) || ({1'b0, a} < lo) || ({1'b0, a} >= hi);
    endfunction

    assign w_bad = (r_state == S_FETCH) && f_addr_bad(r_pc);
`else
    // No address checking: every fetch goes out to IM.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{IM_BASE, 32'(IM_SIZE_WORDS)};
    assign w_bad        = 1'b0;
`endif

    // A bad address completes immediately as a synthetic ack with a zero word.
    assign w_ack       = (r_state == S_FETCH) && (w_bad || im_ack);
    assign w_arr_instr = w_bad ? 32'h0 : im_rdata;

    assign w_consume   = r_valid && !D_stall;
    assign w_slot_free = !r_valid || w_consume;
    // F slot occupied means the delay slot is already fetched: younger words are wrong-path.
    assign w_kill      = redirect && r_valid;
    assign w_take      = w_ack && !r_drop && !w_kill;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_state_nxt;
    end

    // Next state: park in HOLD only when a word arrives with nowhere to go but the skid.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (w_take && !w_slot_free) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_kill || w_slot_free)  w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Outputs: request only while fetching a legal address; address is the held pc.
    always_comb begin
        im_req  = (r_state == S_FETCH) && !w_bad;
        im_addr = r_pc;
    end

    // PC, redirect bookkeeping, F slot and skid register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_tgt        <= RESET_PC;
            r_tgt_pend   <= 1'b0;
            r_drop       <= 1'b0;
            r_valid      <= 1'b0;
            r_slot_pc    <= RESET_PC;
            r_slot_instr <= 32'h0;
            r_slot_exc   <= 1'b0;
            r_skid_pc    <= RESET_PC;
            r_skid_instr <= 32'h0;
            r_skid_exc   <= 1'b0;
        end else begin
            if (w_consume) r_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        r_drop <= 1'b0;
                        if (w_take) begin
                            if (w_slot_free) begin
                                r_slot_pc    <= r_pc;
                                r_slot_instr <= w_arr_instr;
                                r_slot_exc   <= w_bad;
                                r_valid      <= 1'b1;
                            end else begin
                                r_skid_pc    <= r_pc;
                                r_skid_instr <= w_arr_instr;
                                r_skid_exc   <= w_bad;
                            end
                        end
                        // Kill, or the arriving word is itself the delay slot: jump now.
                        if (w_kill || (redirect && !r_drop)) begin
                            r_pc       <= redirect_pc;
                            r_tgt_pend <= 1'b0;
                        end else begin
                            r_pc       <= r_tgt_pend ? r_tgt : r_pc + 32'd4;
                            r_tgt_pend <= redirect;
                            if (redirect) r_tgt <= redirect_pc;
                        end
                    end else if (redirect) begin
                        // Address must stay put until ack; apply the target afterwards.
                        r_tgt      <= redirect_pc;
                        r_tgt_pend <= 1'b1;
                        if (r_valid) r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_kill) begin
                        r_pc       <= redirect_pc;
                        r_tgt_pend <= 1'b0;
                    end else if (w_slot_free) begin
                        r_slot_pc    <= r_skid_pc;
                        r_slot_instr <= r_skid_instr;
                        r_slot_exc   <= r_skid_exc;
                        r_valid      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign F_valid   = r_valid;
    assign F_PC      = r_slot_pc;
    assign F_Instr   = r_slot_instr;
`ifdef IF_FETCH_EXC_EN
    assign F_exc     = r_slot_exc;
    assign F_excCode = r_slot_exc ? 5'd4 : 5'd0;
`else
    logic w_unused_exc;
    assign w_unused_exc = r_slot_exc;
    assign F_exc        = 1'b0;
    assign F_excCode    = 5'd0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed bench for if_fetch_ctrl with a small IM model
// (programmable ack latency, data word = address ^ K).
module tb_if_fetch_ctrl;

    localparam logic [31:0] K = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset;
    logic        D_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        F_valid;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_exc;
    logic [4:0]  F_excCode;

    int n_err = 0;
    int n_chk = 0;
    int lat   = 0;
    int cnt   = 0;

    if_fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_stall    (D_stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .F_valid    (F_valid),
        .F_PC       (F_PC),
        .F_Instr    (F_Instr),
        .F_exc      (F_exc),
        .F_excCode  (F_excCode)
    );

    always #5 clk = ~clk;

    // IM model: ack on the (lat+1)-th cycle of a held request.
    assign im_ack   = im_req && (cnt == lat);
    assign im_rdata = im_addr ^ K;

    always @(posedge clk) begin
        if (reset || !im_req || im_ack) cnt <= 0;
        else                            cnt <= cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int l);
        reset       = 1'b1;
        D_stall     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        lat         = l;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1; D_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; lat = 0;
        tick(); tick();
        chk("rst_F_valid",   F_valid,   32'd0);
        chk("rst_F_PC",      F_PC,      32'h3000);
        chk("rst_F_Instr",   F_Instr,   32'h0);
        chk("rst_F_exc",     F_exc,     32'd0);
        chk("rst_F_excCode", F_excCode, 32'd0);
        chk("rst_im_addr",   im_addr,   32'h3000);
        reset = 1'b0;
        chk("t1_im_req0", im_req, 32'd1);

        // 1: zero-wait stream
        tick();
        chk("t1_valid0", F_valid, 32'd1);
        chk("t1_pc0",    F_PC,    32'h3000);
        chk("t1_instr0", F_Instr, 32'h3000 ^ K);
        chk("t1_addr1",  im_addr, 32'h3004);
        tick();
        chk("t1_pc1",    F_PC,    32'h3004);
        chk("t1_valid1", F_valid, 32'd1);
        tick();
        chk("t1_pc2",    F_PC,    32'h3008);

        // 2: ack on third request cycle
        do_reset(2);
        chk("t2_req_c0",  im_req,  32'd1);
        chk("t2_addr_c0", im_addr, 32'h3000);
        tick();
        chk("t2_req_c1",  im_req,  32'd1);
        chk("t2_addr_c1", im_addr, 32'h3000);
        chk("t2_val_c1",  F_valid, 32'd0);
        tick();
        chk("t2_req_c2",  im_req,  32'd1);
        chk("t2_addr_c2", im_addr, 32'h3000);
        chk("t2_val_c2",  F_valid, 32'd0);
        tick();
        chk("t2_val_c3",  F_valid, 32'd1);
        chk("t2_pc_c3",   F_PC,    32'h3000);
        chk("t2_addr_c3", im_addr, 32'h3004);

        // 3: stall fills slot + skid, then drains in order
        do_reset(0);
        D_stall = 1'b1;
        tick();
        chk("t3_pc_s1", F_PC, 32'h3000);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("t3_req_hold", im_req,  32'd0);
            chk("t3_pc_hold",  F_PC,    32'h3000);
            chk("t3_val_hold", F_valid, 32'd1);
        end
        D_stall = 1'b0;
        tick();
        chk("t3_pc_r1",    F_PC,    32'h3004);
        chk("t3_instr_r1", F_Instr, 32'h3004 ^ K);
        chk("t3_req_r1",   im_req,  32'd1);
        tick();
        chk("t3_pc_r2",    F_PC,    32'h3008);

        // 4: redirect with delay slot in F and next fetch in flight
        do_reset(1);
        tick();
        tick();
        chk("t4_pc0",   F_PC,    32'h3000);
        tick();
        chk("t4_gap",   F_valid, 32'd0);
        tick();
        chk("t4_pc1",   F_PC,    32'h3004);
        chk("t4_val1",  F_valid, 32'd1);
        chk("t4_addr1", im_addr, 32'h3008);
        redirect = 1'b1; redirect_pc = 32'h3100;
        tick();
        redirect = 1'b0;
        chk("t4_val_k",   F_valid, 32'd0);
        chk("t4_req_k",   im_req,  32'd1);
        chk("t4_addr_k",  im_addr, 32'h3008);
        tick();
        chk("t4_dropped", F_valid, 32'd0);
        chk("t4_addr_t",  im_addr, 32'h3100);
        tick();
        chk("t4_wait",    F_valid, 32'd0);
        tick();
        chk("t4_val_t",   F_valid, 32'd1);
        chk("t4_pc_t",    F_PC,    32'h3100);
        chk("t4_instr_t", F_Instr, 32'h3100 ^ K);

        // 5: redirect with F empty, delay slot still in flight
        do_reset(1);
        redirect = 1'b1; redirect_pc = 32'h3200;
        tick();
        redirect = 1'b0;
        tick();
        chk("t5_pc_ds",  F_PC,    32'h3000);
        chk("t5_val_ds", F_valid, 32'd1);
        chk("t5_addr_t", im_addr, 32'h3200);
        tick();
        chk("t5_gap",    F_valid, 32'd0);
        tick();
        chk("t5_pc_t",   F_PC,    32'h3200);
        chk("t5_val_t",  F_valid, 32'd1);

        // 6: redirect in HOLD discards the wrong-path skid word
        do_reset(0);
        D_stall = 1'b1;
        tick();
        tick();
        chk("t6_req_hold", im_req, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h3300; D_stall = 1'b0;
        tick();
        redirect = 1'b0;
        chk("t6_val_k",  F_valid, 32'd0);
        chk("t6_req_k",  im_req,  32'd1);
        chk("t6_addr_k", im_addr, 32'h3300);
        tick();
        chk("t6_pc_t",   F_PC,    32'h3300);

`ifndef IF_FETCH_EXC_EN
        // 7: redirect on the same cycle as ack, target wraps past 2^32
        do_reset(0);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("t7_pc_ds",   F_PC,    32'h3000);
        chk("t7_addr_t",  im_addr, 32'hFFFF_FFFC);
        tick();
        chk("t7_pc_t",    F_PC,    32'hFFFF_FFFC);
        chk("t7_addr_w",  im_addr, 32'h0000_0000);
        tick();
        chk("t7_pc_w",    F_PC,    32'h0000_0000);
        chk("t7_instr_w", F_Instr, 32'h0 ^ K);
        chk("t7_exc",     F_exc,   32'd0);
`else
        // 7: misaligned target raises AdEL without an IM request
        do_reset(0);
        redirect = 1'b1; redirect_pc = 32'h3002;
        tick();
        redirect = 1'b0;
        chk("t7_pc_ds",  F_PC,      32'h3000);
        chk("t7_req_0",  im_req,    32'd0);
        tick();
        chk("t7_pc_e",   F_PC,      32'h3002);
        chk("t7_instr",  F_Instr,   32'h0);
        chk("t7_exc",    F_exc,     32'd1);
        chk("t7_code",   F_excCode, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
